// File: rtl/mem_responder_pkg.sv
// Shared types for the memory responder: FSM state codes, fault causes and
// the latched request record.
package mem_responder_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'b00,
    MEM_WAIT = 2'b01,
    MEM_RESP = 2'b10
  } mem_state_e;

  typedef enum logic [1:0] {
    FAULT_NONE  = 2'b00,
    FAULT_RANGE = 2'b01,
    FAULT_ALIGN = 2'b10
  } fault_e;

  typedef struct packed {
    logic                        we;
    logic [31:0]                 adr;
    logic [31:0]                 wdata;
    logic [WORD_BYTES-1:0]       be;
  } mem_req_t;

  function automatic logic is_misaligned(input logic [31:0] adr);
    return adr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/mem_responder_bram.sv
// bram_be: synchronous single-port RAM, 32-bit words with per-byte write
// enables. dout updates only on enabled cycles and holds otherwise.
module bram_be
  import mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter     INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [WORD_BYTES-1:0] we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           din,
  output logic [31:0]           dout
);

  logic [31:0] mem [2**ADDR_WIDTH];

  // NOTE: the array has no reset branch; clearing a RAM would force it into
  // flops and the contents must survive a core reset anyway.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= din[8*i +: 8];
      end
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the multi-cycle core: accepts one word request,
// inserts WAIT_STATES cycles, then answers with a one-cycle ready pulse.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 10,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] MEM_BASE    = 32'h0000_0000,
  parameter              INIT_FILE   = "program.mem"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

  localparam int         WIN_LSB   = ADDR_WIDTH + 2;
  localparam logic [3:0] WAIT_LAST = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  mem_state_e  state, next_state;
  mem_req_t    req_q, eff;
  fault_e      fault_q, eff_fault;
  logic [3:0]  wait_cnt;
  logic [31:0] rdata_hold;
  logic [31:0] ram_dout;
  logic        accept, commit, ram_en;

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= MEM_IDLE;
    else     state <= next_state;
  end

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    next_state = MEM_IDLE;
    case (state)
      MEM_IDLE: if (req) next_state = (WAIT_STATES == 0) ? MEM_RESP : MEM_WAIT;
      MEM_WAIT: next_state = (wait_cnt == WAIT_LAST) ? MEM_RESP : MEM_WAIT;
      MEM_RESP: next_state = MEM_IDLE;
      default:  next_state = MEM_IDLE;
    endcase
    if (rst) next_state = MEM_IDLE;
  end

  always_comb begin
    ready = 1'b0;
    err   = 1'b0;
    rdata = rdata_hold;
    if (state == MEM_RESP) begin
      ready = 1'b1;
      if (fault_q != FAULT_NONE) begin
        err   = 1'b1;
        rdata = '0;
      end else if (!req_q.we) begin
        rdata = ram_dout;
      end
    end
  end

  // In IDLE the live inputs are the request; afterwards the latched copy is.
  // This lets a zero-wait access commit on its own acceptance edge.
  assign eff = (state == MEM_IDLE)
             ? mem_req_t'{we: we, adr: adr, wdata: wdata, be: be}
             : req_q;

  always_comb begin
    eff_fault = FAULT_NONE;
    if ((eff.adr >> WIN_LSB) != (MEM_BASE >> WIN_LSB)) eff_fault = FAULT_RANGE;
    else if (is_misaligned(eff.adr))                  eff_fault = FAULT_ALIGN;
  end

  assign accept = (state == MEM_IDLE) && req && !rst;
  assign commit = (next_state == MEM_RESP) && (state != MEM_RESP);
  assign ram_en = commit && (eff_fault == FAULT_NONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q      <= '0;
      fault_q    <= FAULT_NONE;
      wait_cnt   <= '0;
      rdata_hold <= '0;
    end else begin
      if (accept) begin
        req_q    <= eff;
        fault_q  <= eff_fault;
        wait_cnt <= '0;
      end else if (state == MEM_WAIT) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
      // Keep the presented response so rdata holds until the next one.
      if (state == MEM_RESP) rdata_hold <= rdata;
    end
  end

  bram_be #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_FILE  (INIT_FILE)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (eff.we ? eff.be : 4'b0000),
    .addr (eff.adr[WIN_LSB-1:2]),
    .din  (eff.wdata),
    .dout (ram_dout)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (WAIT_STATES 0, 1, 2) checked
// against a word-array memory model with plain latency/fault rules.
module tb_mem_responder;

  localparam int N     = 3;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [N];
  logic        req   [N];
  logic        we    [N];
  logic [31:0] adr   [N];
  logic [31:0] wdata [N];
  logic [3:0]  be    [N];
  logic [31:0] rdata [N];
  logic        ready [N];
  logic        err   [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_responder #(
      .ADDR_WIDTH  (AW),
      .WAIT_STATES (g),
      .MEM_BASE    (32'h0000_0000),
      .INIT_FILE   ("")
    ) u_dut (
      .clk   (clk),
      .rst   (rst[g]),
      .req   (req[g]),
      .we    (we[g]),
      .adr   (adr[g]),
      .wdata (wdata[g]),
      .be    (be[g]),
      .rdata (rdata[g]),
      .ready (ready[g]),
      .err   (err[g])
    );
  end

  logic [31:0] model_mem  [N][DEPTH];
  logic [31:0] last_rdata [N];
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit model_fault(input logic [31:0] a);
    return (a >= 32'(DEPTH * 4)) || (a % 4 != 0);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] b);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // One complete access on instance k: latency, err, rdata, pulse width and
  // rdata stability while inputs change after acceptance.
  task automatic access(input int k, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b,
                        input string tag, output logic [31:0] got);
    int          cyc;
    bit          flt;
    logic [31:0] exp_rd;
    flt = model_fault(a);
    @(negedge clk);
    req[k] = 1'b1; we[k] = w; adr[k] = a; wdata[k] = d; be[k] = b;
    @(posedge clk);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) req[k] = 1'b0;
    end while (!ready[k] && cyc < 40);
    check({tag, "/latency"}, 32'(cyc), 32'(k + 1));
    check({tag, "/err"}, 32'(err[k]), 32'(flt));
    if (flt)    exp_rd = 32'h0;
    else if (w) exp_rd = last_rdata[k];
    else        exp_rd = model_mem[k][(a / 4) % DEPTH];
    got = rdata[k];
    check({tag, "/rdata"}, rdata[k], exp_rd);
    if (w && !flt) model_mem[k][a / 4] = merge(model_mem[k][a / 4], d, b);
    last_rdata[k] = exp_rd;
    we[k] = 1'($urandom); adr[k] = $urandom; wdata[k] = $urandom; be[k] = 4'($urandom);
    #1;
    check({tag, "/rdata_stable"}, rdata[k], exp_rd);
    @(negedge clk);
    check({tag, "/pulse_width"}, 32'({ready[k], err[k]}), 32'h0);
    check({tag, "/rdata_hold"}, rdata[k], exp_rd);
  endtask

  logic [31:0] got;
  logic [31:0] a;
  int          pulses, last_cyc, cyc, hits;

  initial begin
    for (int k = 0; k < N; k++) begin
      rst[k] = 1'b1; req[k] = 1'b0; we[k] = 1'b0;
      adr[k] = '0; wdata[k] = '0; be[k] = '0;
      last_rdata[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      rst[k] = 1'b0;
      check($sformatf("reset%0d/outs", k), {rdata[k][29:0], ready[k], err[k]}, 32'h0);
    end

    // Fill words 0..63 of every instance so reads have known contents.
    for (int k = 0; k < N; k++)
      for (int i = 0; i < 64; i++)
        access(k, 1'b1, 32'(i * 4), $urandom, 4'hF, $sformatf("fill%0d", k), got);

    // Directed: read, byte-enable merge, faults, empty-mask write.
    access(1, 1'b1, 32'h0C, 32'hDEADBEEF, 4'hF, "wr_0c", got);
    access(1, 1'b0, 32'h0C, 32'h0, 4'h0, "rd_0c", got);
    check("rd_0c/const", got, 32'hDEADBEEF);
    access(1, 1'b1, 32'h14, 32'h11223344, 4'hF, "wr_14", got);
    access(1, 1'b1, 32'h14, 32'hAABBCCDD, 4'b0101, "wr_14_be", got);
    access(1, 1'b0, 32'h14, 32'h0, 4'h0, "rd_14", got);
    check("rd_14/const", got, 32'h11BB33DD);
    access(1, 1'b0, 32'h0000_1000, 32'h0, 4'h0, "rd_oow", got);
    access(1, 1'b1, 32'h16, 32'hFFFF_FFFF, 4'hF, "wr_misal", got);
    access(1, 1'b1, 32'h14, 32'h5555_5555, 4'h0, "wr_be0", got);
    access(1, 1'b0, 32'h14, 32'h0, 4'h0, "rd_14_again", got);
    check("rd_14_again/const", got, 32'h11BB33DD);
    access(0, 1'b0, 32'h0000_1000, 32'h0, 4'h0, "ws0_oow", got);

    // Back-to-back reads on WAIT_STATES=2 with req held high.
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b0; adr[2] = 32'h08; be[2] = 4'h0;
    pulses = 0; last_cyc = 0; cyc = 0;
    while (pulses < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (ready[2]) begin
        pulses++;
        check($sformatf("b2b/rdata%0d", pulses), rdata[2], model_mem[2][2]);
        if (pulses == 1) check("b2b/first_latency", 32'(cyc), 32'd3);
        else             check($sformatf("b2b/spacing%0d", pulses), 32'(cyc - last_cyc), 32'd4);
        last_cyc = cyc;
        if (pulses == 3) req[2] = 1'b0;
      end
    end
    check("b2b/pulses", 32'(pulses), 32'd3);
    @(negedge clk);
    check("b2b/last_width", 32'(ready[2]), 32'h0);
    last_rdata[2] = model_mem[2][2];

    // Reset during WAIT of a write, then rst and req together.
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h20; wdata[1] = 32'hCAFEF00D; be[1] = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req[1] = 1'b0; rst[1] = 1'b1;
    @(negedge clk);
    req[1] = 1'b1; adr[1] = 32'h20; wdata[1] = 32'h0BADF00D;
    @(negedge clk);
    rst[1] = 1'b0; req[1] = 1'b0;
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      if (ready[1]) hits++;
      @(negedge clk);
    end
    check("rst_mid/no_ready", 32'(hits), 32'd0);
    check("rst_mid/rdata_cleared", rdata[1], 32'h0);
    last_rdata[1] = 32'h0;
    access(1, 1'b0, 32'h20, 32'h0, 4'h0, "rst_mid/read_back", got);

    // Random mix of reads, partial writes and faulting addresses.
    for (int k = 0; k < N; k++) begin
      for (int n = 0; n < 60; n++) begin
        case ($urandom_range(0, 9))
          0: begin
            a = $urandom;
            if (a < 32'(DEPTH * 4)) a = a + 32'(DEPTH * 4);
          end
          1:       a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
          default: a = 32'($urandom_range(0, 63)) << 2;
        endcase
        access(k, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
               $sformatf("rand%0d_%0d", k, n), got);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
